// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: types and constants shared by the memory arbiter and its
// winner-select sub-module.
//   state_e    : arbiter FSM encoding (idle, access in progress, ack cycle)
//   PORT_CPU   : bit index of the CPU requester in a one-hot grant
//   PORT_DMA   : bit index of the loader/debug DMA requester in a one-hot grant
//   CNT_WIDTH  : width of the access-cycle counter (ACCESS_CYCLES up to 15)
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int PORT_CPU  = 0;
    localparam int PORT_DMA  = 1;
    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/memory_arbiter_arb_pick.sv
// arb_pick: combinational winner select for the two-port memory arbiter.
//   req_0      in  CPU request
//   req_1      in  DMA request
//   rr_last    in  port granted most recently (1 = DMA); only consulted on a tie
//   grant_next out one-hot winner, 00 when nobody requests
// Build option: define ARB_ROUND_ROBIN_EN to alternate ties between the ports;
// otherwise the CPU always wins a tie and the DMA port can starve.
module arb_pick
    import memory_arbiter_pkg::*;
(
    input  logic       req_0,
    input  logic       req_1,
    input  logic       rr_last,
    output logic [1:0] grant_next
);

    always_comb begin
        grant_next = 2'b00;
        if (req_0 && req_1) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Tie goes to whichever port did not win last time.
            grant_next[PORT_CPU] = rr_last;
            grant_next[PORT_DMA] = ~rr_last;
`else
            grant_next[PORT_CPU] = 1'b1;
`endif
        end else if (req_0) begin
            grant_next[PORT_CPU] = 1'b1;
        end else if (req_1) begin
            grant_next[PORT_DMA] = 1'b1;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority has no use for the history bit.
    logic unused_rr;
    assign unused_rr = rr_last;
`endif

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single memory_bus port between the CPU (port 0)
// and the loader/debug DMA (port 1). One access at a time: IDLE picks a
// winner and latches its fields, ACCESS holds them on the bus for
// ACCESS_CYCLES cycles, DONE pulses the winner's ack with the captured data.
//   clk, reset                  clock, synchronous active-high reset
//   req_x/we_x/address_x/wdata_x requester x command (held until ack_x)
//   ack_x, rdata_x              one-cycle completion pulse, read data (held)
//   mem_*                       memory_bus address/data/enable/write strobe
//   grant                       one-hot owner of the current access, 00 idle
//   busy                        high whenever the FSM is not idle
//   dbg_state_o                 raw FSM state for debug/observation
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking (see arb_pick).
//
// Handshake: a requester raises req_x with stable fields and keeps them until
// it sees ack_x; the fields are captured on the grant edge, so later changes
// or a dropped req do not disturb an access already under way. Holding req_x
// through the ack cycle counts as the next request.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic        we_0,
    input  logic [15:0] address_0,
    input  logic [7:0]  wdata_0,
    output logic        ack_0,
    output logic [7:0]  rdata_0,
    input  logic        req_1,
    input  logic        we_1,
    input  logic [15:0] address_1,
    input  logic [7:0]  wdata_1,
    output logic        ack_1,
    output logic [7:0]  rdata_1,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out,
    output logic        mem_bus_enable,
    output logic        mem_write_en,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [1:0]           grant_q;
    logic [1:0]           grant_d;
    logic                 ack_0_q, ack_1_q;
    logic [7:0]           rdata_0_q, rdata_1_q;
    logic [15:0]          mem_addr_q;
    logic [7:0]           mem_din_q;
    logic                 mem_en_q, mem_we_q;
    logic                 rr_last;
    logic                 start;

    assign start = (state_q == ST_IDLE) && (req_0 || req_1);

    arb_pick u_pick (
        .req_0      (req_0),
        .req_1      (req_1),
        .rr_last    (rr_last),
        .grant_next (grant_d)
    );

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers who won the latest grant; reset value lets the CPU win the first tie.
    logic rr_last_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else if (start) begin
            rr_last_q <= grant_d[PORT_DMA];
        end
    end
    assign rr_last = rr_last_q;
`else
    assign rr_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            ack_0_q    <= 1'b0;
            ack_1_q    <= 1'b0;
            rdata_0_q  <= 8'h00;
            rdata_1_q  <= 8'h00;
            mem_addr_q <= 16'h0000;
            mem_din_q  <= 8'h00;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_ACCESS;
                        grant_q  <= grant_d;
                        cnt_q    <= CNT_WIDTH'(ACCESS_CYCLES - 1);
                        mem_en_q <= 1'b1;
                        if (grant_d[PORT_CPU]) begin
                            mem_addr_q <= address_0;
                            mem_din_q  <= wdata_0;
                            mem_we_q   <= we_0;
                        end else begin
                            mem_addr_q <= address_1;
                            mem_din_q  <= wdata_1;
                            mem_we_q   <= we_1;
                        end
                    end
                end
                ST_ACCESS: begin
                    // memory_bus registers the strobe, so one cycle of it is one write.
                    mem_we_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q    <= ST_DONE;
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= 16'h0000;
                        mem_din_q  <= 8'h00;
                        if (grant_q[PORT_CPU]) begin
                            rdata_0_q <= mem_data_out;
                            ack_0_q   <= 1'b1;
                        end else begin
                            rdata_1_q <= mem_data_out;
                            ack_1_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    ack_0_q <= 1'b0;
                    ack_1_q <= 1'b0;
                    grant_q <= 2'b00;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_0          = ack_0_q;
    assign ack_1          = ack_1_q;
    assign rdata_0        = rdata_0_q;
    assign rdata_1        = rdata_1_q;
    assign mem_address    = mem_addr_q;
    assign mem_data_in    = mem_din_q;
    assign mem_bus_enable = mem_en_q;
    assign mem_write_en   = mem_we_q;
    assign grant          = grant_q;
    assign busy           = (state_q != ST_IDLE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: main instance with ACCESS_CYCLES=2 driven by
// directed and random transactions from both ports, plus a second instance
// with ACCESS_CYCLES=1 for back-to-back CPU reads. Memory read data is a fixed
// function of the bus address, so every access has a known expected rdata.
module tb_memory_arbiter;

  localparam int AC    = 2;
  localparam int BOUND = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT signals ----------------
  logic        req_0, we_0, req_1, we_1;
  logic [15:0] address_0, address_1;
  logic [7:0]  wdata_0, wdata_1;
  logic        ack_0, ack_1;
  logic [7:0]  rdata_0, rdata_1;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_in, mem_data_out;
  logic        mem_bus_enable, mem_write_en;
  logic [1:0]  grant;
  logic        busy;
  logic [1:0]  dbg_state;

  // ---------------- ACCESS_CYCLES=1 DUT signals ----------------
  logic        f_req_0, f_we_0, f_req_1, f_we_1;
  logic [15:0] f_address_0, f_address_1;
  logic [7:0]  f_wdata_0, f_wdata_1;
  logic        f_ack_0, f_ack_1;
  logic [7:0]  f_rdata_0, f_rdata_1;
  logic [15:0] f_mem_address;
  logic [7:0]  f_mem_data_in, f_mem_data_out;
  logic        f_mem_bus_enable, f_mem_write_en;
  logic [1:0]  f_grant;
  logic        f_busy;
  logic [1:0]  f_dbg_state;

  function automatic logic [7:0] rd_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h0A;
  endfunction

  assign mem_data_out   = rd_fn(mem_address);
  assign f_mem_data_out = rd_fn(f_mem_address);

  memory_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .we_0(we_0), .address_0(address_0), .wdata_0(wdata_0),
    .ack_0(ack_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .address_1(address_1), .wdata_1(wdata_1),
    .ack_1(ack_1), .rdata_1(rdata_1),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_bus_enable(mem_bus_enable), .mem_write_en(mem_write_en),
    .grant(grant), .busy(busy), .dbg_state_o(dbg_state)
  );

  memory_arbiter #(.ACCESS_CYCLES(1)) dut_f (
    .clk(clk), .reset(reset),
    .req_0(f_req_0), .we_0(f_we_0), .address_0(f_address_0), .wdata_0(f_wdata_0),
    .ack_0(f_ack_0), .rdata_0(f_rdata_0),
    .req_1(f_req_1), .we_1(f_we_1), .address_1(f_address_1), .wdata_1(f_wdata_1),
    .ack_1(f_ack_1), .rdata_1(f_rdata_1),
    .mem_address(f_mem_address), .mem_data_in(f_mem_data_in), .mem_data_out(f_mem_data_out),
    .mem_bus_enable(f_mem_bus_enable), .mem_write_en(f_mem_write_en),
    .grant(f_grant), .busy(f_busy), .dbg_state_o(f_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [24:0] exp_q0[$];   // {we, address, wdata} per outstanding port 0 request
  logic [24:0] exp_q1[$];
  logic [1:0]  grant_log[$];
  logic [1:0]  t3_exp[4];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor ----------------
  bit          in_flight = 0;
  int          g_cyc, en_cnt, strobe_cnt;
  logic [15:0] s_addr;
  logic [7:0]  s_data;
  bit          prev_r0 = 0, prev_r1 = 0;
  bit          rr_last_m = 1;   // last granted port was DMA
  logic [1:0]  pick;
  logic [24:0] e_m;
  int          p_m;

  always @(negedge clk) begin
    if (reset) begin
      exp_q0.delete();
      exp_q1.delete();
      in_flight = 0;
      rr_last_m = 1;
    end else begin
      if (!in_flight && grant != 2'b00) begin
        // Winner from the requests that were present at the grant edge.
        if (prev_r0 && prev_r1) begin
`ifdef ARB_ROUND_ROBIN_EN
          pick = rr_last_m ? 2'b01 : 2'b10;
`else
          pick = 2'b01;
`endif
        end else if (prev_r0) begin
          pick = 2'b01;
        end else begin
          pick = 2'b10;
        end
        check("grant_pick", grant, pick);
        rr_last_m = (pick == 2'b10);
        grant_log.push_back(grant);
        in_flight  = 1;
        g_cyc      = cyc;
        en_cnt     = 0;
        strobe_cnt = 0;
      end
      if (mem_bus_enable) begin
        en_cnt++;
        if (!in_flight) check("enable_while_idle", 1, 0);
      end
      if (mem_write_en) begin
        strobe_cnt++;
        s_addr = mem_address;
        s_data = mem_data_in;
        if (!in_flight) check("strobe_while_idle", 1, 0);
      end
      if (ack_0 || ack_1) begin
        p_m = ack_0 ? 0 : 1;
        if (ack_0 && ack_1) begin
          check("dual_ack", 1, 0);
        end else if ((p_m == 0 && exp_q0.size() == 0) || (p_m == 1 && exp_q1.size() == 0)) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: port %0d acked with no request outstanding (cycle %0d)", p_m, cyc);
        end else begin
          if (p_m == 0) e_m = exp_q0.pop_front();
          else          e_m = exp_q1.pop_front();
          check("ack_rdata", (p_m == 0) ? rdata_0 : rdata_1, rd_fn(e_m[23:8]));
          check("ack_grant", grant, (p_m == 0) ? 2'b01 : 2'b10);
          check("ack_busy", busy, 1);
          check("ack_latency", cyc - g_cyc, AC);
          check("enable_cycles", en_cnt, AC);
          check("write_strobes", strobe_cnt, e_m[24]);
          if (e_m[24]) begin
            check("strobe_addr", s_addr, e_m[23:8]);
            check("strobe_data", s_data, e_m[7:0]);
          end
        end
        in_flight = 0;
      end
    end
    prev_r0 = req_0;
    prev_r1 = req_1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((p == 0) ? ack_0 : ack_1) && n < BOUND);
    n_checks++;
    if (!((p == 0) ? ack_0 : ack_1)) begin
      n_fail++;
      $display("FAIL ack_timeout: port %0d got no ack, required one within %0d cycles", p, BOUND);
    end
  endtask

  task automatic wait_grant();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 2'b00 && n < BOUND);
    check("grant_timeout", (grant != 2'b00), 1);
  endtask

  // Called just after a rising edge; returns just after the edge that follows the ack.
  task automatic port_txn(input int p, input bit we, input logic [15:0] a,
                          input logic [7:0] d, input bit keep);
    if (p == 0) begin
      we_0 = we; address_0 = a; wdata_0 = d; req_0 = 1'b1;
      exp_q0.push_back({we, a, d});
    end else begin
      we_1 = we; address_1 = a; wdata_1 = d; req_1 = 1'b1;
      exp_q1.push_back({we, a, d});
    end
    wait_ack(p);
    @(posedge clk); #1;
    if (!keep) begin
      if (p == 0) req_0 = 1'b0;
      else        req_1 = 1'b0;
    end
  endtask

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      port_txn(p, 1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
               (gap == 0) && (i != n - 1));
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  int          n6;
  int          last_ack;
  logic [15:0] f_a;

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    t3_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    t3_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    reset = 1'b1;
    req_0 = 0; we_0 = 0; address_0 = 0; wdata_0 = 0;
    req_1 = 0; we_1 = 0; address_1 = 0; wdata_1 = 0;
    f_req_0 = 0; f_we_0 = 0; f_address_0 = 0; f_wdata_0 = 0;
    f_req_1 = 0; f_we_1 = 0; f_address_1 = 0; f_wdata_1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_ack_0", ack_0, 0);
    check("rst_ack_1", ack_1, 0);
    check("rst_rdata_0", rdata_0, 0);
    check("rst_rdata_1", rdata_1, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    check("rst_mem_bus_enable", mem_bus_enable, 0);
    check("rst_mem_write_en", mem_write_en, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Port 0 read of 0x4010: memory returns 0x5A.
    port_txn(0, 1'b0, 16'h4010, 8'h00, 1'b0);
    check("t1_rdata_0_held", rdata_0, 8'h5A);

    // Port 1 write 0xC123 <- 0x77.
    port_txn(1, 1'b1, 16'hC123, 8'h77, 1'b0);
    check("t2_rdata_1_held", rdata_1, 8'hE8);

    // Both ports requesting continuously.
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) port_txn(0, 1'b0, 16'h0100 + 16'(i), 8'h00, i != 3);
      end
      begin
        for (int i = 0; i < 4; i++) port_txn(1, 1'b1, 16'h0200 + 16'(i), 8'h30 + 8'(i), i != 3);
      end
    join
    check("t3_grants_logged", (grant_log.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) check($sformatf("t3_grant_%0d", i), grant_log[i], t3_exp[i]);
    end

    // Port 0 write, req dropped one cycle after the grant.
    repeat (2) @(posedge clk); #1;
    we_0 = 1'b1; address_0 = 16'h2222; wdata_0 = 8'h3C; req_0 = 1'b1;
    exp_q0.push_back({1'b1, 16'h2222, 8'h3C});
    wait_grant();
    @(posedge clk); #1;
    req_0 = 1'b0;
    wait_ack(0);
    repeat (3) @(negedge clk);
    check("t4_idle_after", busy, 0);

    // Reset during the second ACCESS cycle of a port 1 read.
    @(posedge clk); #1;
    we_1 = 1'b0; address_1 = 16'h8001; req_1 = 1'b1;
    exp_q1.push_back({1'b0, 16'h8001, 8'h00});
    wait_grant();
    @(posedge clk); #1;
    reset = 1'b1;
    req_1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_grant", grant, 0);
    check("t5_ack_1", ack_1, 0);
    check("t5_mem_address", mem_address, 0);
    check("t5_mem_data_in", mem_data_in, 0);
    check("t5_mem_bus_enable", mem_bus_enable, 0);
    check("t5_mem_write_en", mem_write_en, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Random traffic from both ports.
    fork
      rand_port(0, 25);
      rand_port(1, 25);
    join
    repeat (4) @(posedge clk); #1;

    // ACCESS_CYCLES=1 instance: back-to-back port 0 reads.
    f_a = 16'h1234;
    f_we_0 = 1'b0; f_address_0 = f_a; f_req_0 = 1'b1;
    last_ack = cyc;
    for (int k = 0; k < 4; k++) begin
      n6 = 0;
      do begin
        @(negedge clk);
        n6++;
      end while (!f_ack_0 && n6 < 50);
      check("t6_ack_seen", f_ack_0, 1);
      check("t6_rdata_0", f_rdata_0, rd_fn(f_a));
      check("t6_no_ack_1", f_ack_1, 0);
      if (k == 0) check("t6_first_latency", cyc - last_ack, 2);
      else        check("t6_ack_period", cyc - last_ack, 3);
      last_ack = cyc;
      @(posedge clk); #1;
      f_a = 16'($urandom);
      f_address_0 = f_a;
      if (k == 3) f_req_0 = 1'b0;
    end

    repeat (6) @(negedge clk);
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
    check("end_busy", busy, 0);
    check("end_f_busy", f_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
